// File: rtl/pc_sequencer_pkg.sv
// Shared processor-control definitions: BROP branch encodings and sequencer state type.
// The instruction decoder uses the same BROP constants.
package pc_sequencer_pkg;

  localparam logic [2:0] BR_NONE   = 3'b000;
  localparam logic [2:0] BR_Z      = 3'b001;
  localparam logic [2:0] BR_N      = 3'b010;
  localparam logic [2:0] BR_SUB    = 3'b011;
  localparam logic [2:0] BR_ALWAYS = 3'b100;
  localparam logic [2:0] BR_RET    = 3'b101;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: register-file storage plus an occupancy counter.
// Push is dropped when full and pop when empty; the caller faults on those cases.
module ret_stack #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [ADDR_W-1:0]            i_din,
  output logic [ADDR_W-1:0]            o_top,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_depth;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_depth == CNT_W'(DEPTH));
  assign o_empty   = (r_depth == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_wr_idx  = r_depth[IDX_W-1:0];
  assign w_rd_idx  = IDX_W'(r_depth - CNT_W'(1));
  assign o_top     = r_mem[w_rd_idx];
  assign o_depth   = r_depth;

  // Contents need no reset; only the occupancy count defines validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + CNT_W'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and branch sequencer with return-address stack and sticky fault-halt.
// State advances only on en ticks; HALT is left only through reset.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          DEPTH     = 8,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [2:0]                   BROP,
  input  logic                         zero_flag,
  input  logic                         neg_flag,
  input  logic [ADDR_W-1:0]            target,
  output logic [ADDR_W-1:0]            PC,
  output logic [$clog2(DEPTH+1)-1:0]   stack_depth,
  output logic                         halted,
  output logic                         stack_ovf,
  output logic                         stack_unf
);

  seq_state_e        r_state;
  seq_state_e        w_state_d;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_d;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_top;
  logic              r_ovf;
  logic              w_ovf_d;
  logic              r_unf;
  logic              w_unf_d;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  assign w_inc = r_pc + ADDR_W'(1);

  ret_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ret_stack (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_inc),
    .o_top   (w_top),
    .o_depth (stack_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_pc_d    = r_pc;
    w_state_d = r_state;
    w_ovf_d   = r_ovf;
    w_unf_d   = r_unf;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    if (en && (r_state == StRun)) begin
      case (BROP)
        BR_Z:      w_pc_d = zero_flag ? target : w_inc;
        BR_N:      w_pc_d = neg_flag ? target : w_inc;
        BR_ALWAYS: w_pc_d = target;
        BR_SUB: begin
          if (!w_full) begin
            w_push = 1'b1;
            w_pc_d = target;
          end else begin
            w_ovf_d   = 1'b1;
            w_state_d = StHalt;
          end
        end
        BR_RET: begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_pc_d = w_top;
          end else begin
            w_unf_d   = 1'b1;
            w_state_d = StHalt;
          end
        end
        // BR_NONE and the reserved codes fall through to a plain increment.
        default:   w_pc_d = w_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_pc    <= RESET_VEC;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_ovf   <= w_ovf_d;
      r_unf   <= w_unf_d;
    end
  end

  assign PC        = r_pc;
  assign halted    = (r_state == StHalt);
  assign stack_ovf = r_ovf;
  assign stack_unf = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized ops
// checked against a queue-based reference model.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [2:0]        BROP;
  logic              zero_flag;
  logic              neg_flag;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] PC;
  logic [3:0]        stack_depth;
  logic              halted;
  logic              stack_ovf;
  logic              stack_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_halt;
  logic       m_ovf;
  logic       m_unf;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .RESET_VEC (8'h00)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .BROP        (BROP),
    .zero_flag   (zero_flag),
    .neg_flag    (neg_flag),
    .target      (target),
    .PC          (PC),
    .stack_depth (stack_depth),
    .halted      (halted),
    .stack_ovf   (stack_ovf),
    .stack_unf   (stack_unf)
  );

  task automatic do_reset(input logic e);
    rst_n  = 1'b0;
    en     = e;
    BROP   = BR_ALWAYS;
    target = 8'hAA;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    en     = 1'b0;
    m_pc   = 8'h00;
    m_stk.delete();
    m_halt = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic step(input logic e, input logic [2:0] op, input logic z, input logic n,
                      input logic [7:0] tgt);
    en        = e;
    BROP      = op;
    zero_flag = z;
    neg_flag  = n;
    target    = tgt;
    @(posedge clk);
    #1;
    en = 1'b0;
    if (e && !m_halt) begin
      case (op)
        3'd1: m_pc = z ? tgt : m_pc + 8'd1;
        3'd2: m_pc = n ? tgt : m_pc + 8'd1;
        3'd4: m_pc = tgt;
        3'd3: begin
          if (m_stk.size() < DEPTH) begin
            m_stk.push_back(m_pc + 8'd1);
            m_pc = tgt;
          end else begin
            m_ovf  = 1'b1;
            m_halt = 1'b1;
          end
        end
        3'd5: begin
          if (m_stk.size() > 0) begin
            m_pc = m_stk.pop_back();
          end else begin
            m_unf  = 1'b1;
            m_halt = 1'b1;
          end
        end
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if (PC !== 8'h00 || stack_depth !== 4'd0 || halted !== 1'b0 || stack_ovf !== 1'b0 ||
        stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset: PC=%h depth=%0d halt=%b ovf=%b unf=%b, required 00 0 0 0 0",
               PC, stack_depth, halted, stack_ovf, stack_unf);
    end
  endtask

  task automatic test_sequential();
    do_reset(1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, BR_NONE, 1'b1, 1'b1, 8'h77);
      checks++;
      if (PC !== 8'(i)) begin
        errors++;
        $display("FAIL seq_tick: PC=%h, required %h", PC, 8'(i));
      end
      step(1'b0, BR_ALWAYS, 1'b0, 1'b0, 8'h77);
      checks++;
      if (PC !== 8'(i)) begin
        errors++;
        $display("FAIL en_low_hold: PC=%h, required %h", PC, 8'(i));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    step(1'b1, BR_ALWAYS, 1'b0, 1'b0, 8'hFF);
    step(1'b1, BR_NONE, 1'b0, 1'b0, 8'h12);
    checks++;
    if (PC !== 8'h00 || halted !== 1'b0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL wrap: PC=%h halt=%b ovf=%b unf=%b, required 00 0 0 0",
               PC, halted, stack_ovf, stack_unf);
    end
  endtask

  task automatic test_cond_branch();
    do_reset(1'b0);
    step(1'b1, BR_ALWAYS, 1'b0, 1'b0, 8'h10);
    step(1'b1, BR_Z, 1'b0, 1'b1, 8'h40);
    checks++;
    if (PC !== 8'h11) begin
      errors++;
      $display("FAIL brz_not_taken: PC=%h, required 11", PC);
    end
    step(1'b1, BR_ALWAYS, 1'b0, 1'b0, 8'h10);
    step(1'b1, BR_Z, 1'b1, 1'b0, 8'h40);
    checks++;
    if (PC !== 8'h40) begin
      errors++;
      $display("FAIL brz_taken: PC=%h, required 40", PC);
    end
    step(1'b1, BR_N, 1'b0, 1'b1, 8'h55);
    checks++;
    if (PC !== 8'h55) begin
      errors++;
      $display("FAIL brn_taken: PC=%h, required 55", PC);
    end
    step(1'b1, BR_N, 1'b1, 1'b0, 8'h99);
    checks++;
    if (PC !== 8'h56) begin
      errors++;
      $display("FAIL brn_not_taken: PC=%h, required 56", PC);
    end
  endtask

  task automatic test_nested();
    do_reset(1'b0);
    step(1'b1, BR_ALWAYS, 1'b0, 1'b0, 8'h05);
    step(1'b1, BR_SUB, 1'b0, 1'b0, 8'h20);
    step(1'b1, BR_SUB, 1'b0, 1'b0, 8'h30);
    checks++;
    if (PC !== 8'h30 || stack_depth !== 4'd2) begin
      errors++;
      $display("FAIL nested_call: PC=%h depth=%0d, required 30 2", PC, stack_depth);
    end
    step(1'b1, BR_RET, 1'b0, 1'b0, 8'hEE);
    checks++;
    if (PC !== 8'h21 || stack_depth !== 4'd1) begin
      errors++;
      $display("FAIL nested_ret1: PC=%h depth=%0d, required 21 1", PC, stack_depth);
    end
    step(1'b1, BR_RET, 1'b0, 1'b0, 8'hEE);
    checks++;
    if (PC !== 8'h06 || stack_depth !== 4'd0) begin
      errors++;
      $display("FAIL nested_ret2: PC=%h depth=%0d, required 06 0", PC, stack_depth);
    end
  endtask

  task automatic test_overflow();
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, BR_SUB, 1'b0, 1'b0, 8'h80 + 8'(i));
    checks++;
    if (PC !== 8'h87 || stack_depth !== 4'd8 || halted !== 1'b0 || stack_ovf !== 1'b0) begin
      errors++;
      $display("FAIL fill_last: PC=%h depth=%0d halt=%b ovf=%b, required 87 8 0 0",
               PC, stack_depth, halted, stack_ovf);
    end
    step(1'b1, BR_SUB, 1'b0, 1'b0, 8'hC0);
    checks++;
    if (PC !== 8'h87 || stack_depth !== 4'd8 || halted !== 1'b1 || stack_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: PC=%h depth=%0d halt=%b ovf=%b, required 87 8 1 1",
               PC, stack_depth, halted, stack_ovf);
    end
    step(1'b1, BR_RET, 1'b0, 1'b0, 8'h00);
    step(1'b1, BR_ALWAYS, 1'b0, 1'b0, 8'h33);
    checks++;
    if (PC !== 8'h87 || stack_depth !== 4'd8 || halted !== 1'b1 || stack_unf !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen: PC=%h depth=%0d halt=%b unf=%b, required 87 8 1 0",
               PC, stack_depth, halted, stack_unf);
    end
    do_reset(1'b1);
    checks++;
    if (PC !== 8'h00 || stack_depth !== 4'd0 || halted !== 1'b0 || stack_ovf !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: PC=%h depth=%0d halt=%b ovf=%b, required 00 0 0 0",
               PC, stack_depth, halted, stack_ovf);
    end
  endtask

  task automatic test_underflow();
    do_reset(1'b0);
    step(1'b1, BR_RET, 1'b0, 1'b0, 8'h44);
    checks++;
    if (PC !== 8'h00 || halted !== 1'b1 || stack_unf !== 1'b1 || stack_ovf !== 1'b0) begin
      errors++;
      $display("FAIL underflow: PC=%h halt=%b unf=%b ovf=%b, required 00 1 1 0",
               PC, halted, stack_unf, stack_ovf);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, BR_SUB, 1'b0, 1'b0, 8'h10 * 8'(i + 1));
    checks++;
    if (stack_depth !== 4'd3) begin
      errors++;
      $display("FAIL mid_depth: depth=%0d, required 3", stack_depth);
    end
    do_reset(1'b1);
    checks++;
    if (PC !== 8'h00 || stack_depth !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid: PC=%h depth=%0d, required 00 0", PC, stack_depth);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int r = 0; r < 12; r++) begin
      do_reset(1'b0);
      for (int s = 0; s < 40; s++) begin
        // Bias toward calls so deep stacks and overflow get exercised.
        op = ($urandom_range(0, 3) == 0) ? BR_SUB : 3'($urandom_range(0, 7));
        step(($urandom_range(0, 3) != 0), op, 1'($urandom), 1'($urandom), 8'($urandom));
        checks++;
        if (PC !== m_pc || stack_depth !== 4'(m_stk.size()) || halted !== m_halt ||
            stack_ovf !== m_ovf || stack_unf !== m_unf) begin
          errors++;
          $display("FAIL random r%0d s%0d: PC=%h d=%0d h=%b o=%b u=%b, required %h %0d %b %b %b",
                   r, s, PC, stack_depth, halted, stack_ovf, stack_unf,
                   m_pc, m_stk.size(), m_halt, m_ovf, m_unf);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    BROP      = BR_NONE;
    zero_flag = 1'b0;
    neg_flag  = 1'b0;
    target    = '0;
    test_reset();
    test_sequential();
    test_wrap();
    test_cond_branch();
    test_nested();
    test_overflow();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and branch sequencer for the 16-bit single-cycle core. It consumes the 3-bit BROP branch code from the instruction decoder, the ALU zero/negative flags and the instruction's branch target. Each instruction-advance tick it produces the next instruction address. It owns an internal return-address stack for BRSUB/RETURN and enters a sticky fault-halt on stack overflow or underflow.

Parameters:
ADDR_W, 8, width of the program counter and branch target.
DEPTH, 8, return-stack entries; must be at least 1.
RESET_VEC, 0, PC value after reset.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
en  in  1  instruction-advance tick from the clock divider; state changes only when en=1
BROP  in  3  branch op from the decoder: 000 none, 001 BRZ, 010 BRN, 011 BRSUB, 100 BR, 101 RETURN, 110/111 reserved
zero_flag  in  1  ALU result == 0, valid in the cycle en=1
neg_flag  in  1  ALU result negative, valid in the cycle en=1
target  in  ADDR_W  branch/subroutine target address
PC  out  ADDR_W  current instruction address (registered)
stack_depth  out  $clog2(DEPTH+1)  occupied return-stack entries
halted  out  1  1 in the HALT state
stack_ovf  out  1  sticky: BRSUB attempted with a full stack
stack_unf  out  1  sticky: RETURN attempted with an empty stack

Behaviour:
- Reset: synchronous on the clk edge with rst_n=0; it overrides en. Results: PC=RESET_VEC, stack_depth=0, halted=0, stack_ovf=0, stack_unf=0, state RUN. Stack contents are don't-care. Reset mid-subroutine discards all return addresses.
- States: RUN and HALT. HALT is left only by reset.
- All outputs are registered and change one clk edge after an en=1 cycle. Latency is one en-cycle per instruction. With en=0 all state holds.
- In RUN with en=1, inc = PC+1 modulo 2^ADDR_W (wraps from all-ones to 0 with no flag).
  - 000, 110 or 111: PC<=inc.
  - 001 BRZ: PC<=target if zero_flag=1, else inc.
  - 010 BRN: PC<=target if neg_flag=1, else inc.
  - 100 BR: PC<=target.
  - 011 BRSUB with depth<DEPTH: push inc, depth+1, PC<=target.
  - 011 BRSUB with depth==DEPTH: no push, PC holds, stack_ovf<=1, go to HALT.
  - 101 RETURN with depth>0: PC<=top entry, depth-1.
  - 101 RETURN with depth==0: PC holds, stack_unf<=1, go to HALT.
- Flags are ignored for every op other than BRZ/BRN. When both flags are 1, BRZ and BRN each act on their own flag only.
- Push and pop never occur in the same cycle, because BROP selects exactly one op.
- BRSUB filling the last entry (depth DEPTH-1 to DEPTH) is legal and does not fault.
- HALT: PC, stack and depth frozen; BROP, flags and en ignored; halted=1.
- The stack is LIFO. The entry popped is always the most recent unpopped push.

Decomposition:
- Shared package (processor control pkg): BROP encodings as named constants BR_NONE=000, BR_Z=001, BR_N=010, BR_SUB=011, BR_ALWAYS=100, BR_RET=101. The decoder adopts the same constants.
- One sub-module, ret_stack (parameters DEPTH, ADDR_W):
  - inputs: push, pop, din
  - outputs: top, depth, full, empty
  - synchronous memory plus a depth counter; reset clears depth.
- pc_sequencer holds the RUN/HALT FSM, next-PC mux and sticky flags.

Test Plan:
- Reset then 5 en-cycles with BROP=000, ADDR_W=8 -> PC 0,1,2,3,4,5; en=0 cycles between ticks -> PC holds.
- PC=0xFF, BROP=000, en=1 -> PC=0x00, no flag set.
- PC=0x10, target=0x40: BRZ with zero_flag=0 -> PC=0x11; BRZ with zero_flag=1 -> PC=0x40; BRN with neg_flag=1, zero_flag=0 -> PC=target.
- Nested calls: PC=0x05 BRSUB target 0x20, then at 0x20 BRSUB target 0x30.
  - Result: depth=2, PC=0x30.
  - RETURN -> PC=0x21, depth=1.
  - RETURN -> PC=0x06, depth=0.
- DEPTH=8: nine consecutive BRSUBs -> eighth succeeds with depth=8; ninth gives stack_ovf=1, halted=1, PC unchanged; further ops ignored until rst_n=0 clears everything.
- RETURN immediately after reset -> stack_unf=1, halted=1, PC=RESET_VEC.
- rst_n=0 asserted with depth=3 and en=1 on the same edge -> PC=RESET_VEC, depth=0.
